// File: rtl/main_control.sv
// Multicycle RISC-V control FSM. Per-state strobes are precomputed from the
// next state and registered, so they change only on the clock edge.
module main_control (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [6:0] iOpcode,
  input  logic [2:0] iFunct3,
  input  logic       iZero,
  output logic [1:0] oALUOp,
  output logic [1:0] oALUSrcA,
  output logic [1:0] oALUSrcB,
  output logic [1:0] oResultSrc,
  output logic       oAdrSrc,
  output logic       oIRWrite,
  output logic       oPCWrite,
  output logic       oRegWrite,
  output logic       oMemWrite,
  output logic [3:0] oState,
  output logic       oIllegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] res_src;
    logic       adr_src;
    logic       ir_wr;
    logic       pc_wr;
    logic       reg_wr;
    logic       mem_wr;
  } ctrl_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  function automatic ctrl_t ctrl_of(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.ir_wr = 1'b1; c.pc_wr = 1'b1; c.src_b = 2'b10; c.res_src = 2'b10; end
      S_DECODE:   begin c.src_a = 2'b01; c.src_b = 2'b01; end
      S_MEMADR:   begin c.src_a = 2'b10; c.src_b = 2'b01; end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB:    begin c.res_src = 2'b01; c.reg_wr = 1'b1; end
      S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_wr = 1'b1; end
      S_EXECR:    begin c.src_a = 2'b10; c.alu_op = 2'b10; end
      S_EXECI:    begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu_op = 2'b11; end
      S_ALUWB:    c.reg_wr = 1'b1;
      S_JAL:      begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_wr = 1'b1; end
      // BRANCH pc_wr is resolved combinationally from the zero flag below
      S_BRANCH:   begin c.src_a = 2'b10; c.alu_op = 2'b01; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   op_bad, br_bad, br_take;

  assign op_bad = !(iOpcode inside {OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL});
  assign br_bad = (iFunct3[2:1] != 2'b00);
  assign br_take = (iFunct3 == 3'b000) ? iZero :
                   (iFunct3 == 3'b001) ? ~iZero : 1'b0;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (iOpcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_B:         state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (iOpcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_of(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_of(state_d);
    end
  end

  assign oALUOp     = ctrl_q.alu_op;
  assign oALUSrcA   = ctrl_q.src_a;
  assign oALUSrcB   = ctrl_q.src_b;
  assign oResultSrc = ctrl_q.res_src;
  assign oAdrSrc    = ctrl_q.adr_src;
  assign oIRWrite   = ctrl_q.ir_wr;
  assign oRegWrite  = ctrl_q.reg_wr;
  assign oMemWrite  = ctrl_q.mem_wr;
  assign oPCWrite   = (state_q == S_BRANCH) ? br_take : ctrl_q.pc_wr;
  assign oState     = state_q;
  assign oIllegal   = ((state_q == S_DECODE) && op_bad) ||
                      ((state_q == S_BRANCH) && br_bad);

endmodule

// File: tb/tb_main_control.sv
// Directed bench for main_control: walks each instruction class through its
// state sequence and checks every control output against a per-state table.
module tb_main_control;
  logic       iClk = 1'b0;
  logic       iRst_n;
  logic [6:0] iOpcode;
  logic [2:0] iFunct3;
  logic       iZero;
  logic [1:0] oALUOp, oALUSrcA, oALUSrcB, oResultSrc;
  logic       oAdrSrc, oIRWrite, oPCWrite, oRegWrite, oMemWrite, oIllegal;
  logic [3:0] oState;

  int n_cmp = 0;
  int n_err = 0;

  main_control dut (
    .iClk(iClk), .iRst_n(iRst_n), .iOpcode(iOpcode), .iFunct3(iFunct3),
    .iZero(iZero), .oALUOp(oALUOp), .oALUSrcA(oALUSrcA), .oALUSrcB(oALUSrcB),
    .oResultSrc(oResultSrc), .oAdrSrc(oAdrSrc), .oIRWrite(oIRWrite),
    .oPCWrite(oPCWrite), .oRegWrite(oRegWrite), .oMemWrite(oMemWrite),
    .oState(oState), .oIllegal(oIllegal)
  );

  always #5 iClk = ~iClk;

  // {ALUOp, SrcA, SrcB, ResultSrc, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite}
  function automatic logic [12:0] obs();
    return {oALUOp, oALUSrcA, oALUSrcB, oResultSrc, oAdrSrc, oIRWrite,
            oPCWrite, oRegWrite, oMemWrite};
  endfunction

  function automatic logic [12:0] exp_ctrl(input int st, input logic pcw);
    case (st)
      0:  return {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      1:  return {2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      2:  return {2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      3:  return {2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      4:  return {2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      5:  return {2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      6:  return {2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      7:  return {2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      8:  return {2'b11, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      9:  return {2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      10: return {2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, pcw,  1'b0, 1'b0};
      default: return '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic test_reset();
    iRst_n = 1'b0; iOpcode = 7'b0000011; iFunct3 = 3'b000; iZero = 1'b0;
    #12;
    n_cmp++; if (oState !== 4'd0) begin n_err++; $display("FAIL rst_state got %0d want 0", oState); end
    n_cmp++; if (obs() !== exp_ctrl(0, 1'b0)) begin n_err++; $display("FAIL rst_outs got %h want %h", obs(), exp_ctrl(0, 1'b0)); end
    n_cmp++; if (oIllegal !== 1'b0) begin n_err++; $display("FAIL rst_illegal got %b want 0", oIllegal); end
    @(posedge iClk); #1 iRst_n = 1'b1;
    tick();
    n_cmp++; if (oState !== 4'd1) begin n_err++; $display("FAIL rst_release got %0d want 1", oState); end
    #2 iRst_n = 1'b0;
    #1;
    n_cmp++; if (oState !== 4'd0) begin n_err++; $display("FAIL rst_async got %0d want 0", oState); end
    @(posedge iClk); #1 iRst_n = 1'b1;
  endtask

  task automatic test_lw();
    int s[6] = '{0, 1, 2, 3, 4, 0};
    iOpcode = 7'b0000011;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      // opcode is not sampled after MEMADR, so garbage here must be ignored
      if (s[i] == 3) iOpcode = 7'b1111111;
      n_cmp++; if (oState !== 4'(s[i])) begin n_err++; $display("FAIL lw_state[%0d] got %0d want %0d", i, oState, s[i]); end
      n_cmp++; if (obs() !== exp_ctrl(s[i], 1'b0)) begin n_err++; $display("FAIL lw_outs[%0d] got %h want %h", i, obs(), exp_ctrl(s[i], 1'b0)); end
      n_cmp++; if (oALUOp !== 2'b00) begin n_err++; $display("FAIL lw_aluop[%0d] got %b want 00", i, oALUOp); end
    end
  endtask

  task automatic test_sw();
    int s[5] = '{0, 1, 2, 5, 0};
    int mw = 0;
    iOpcode = 7'b0100011;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      if (oMemWrite === 1'b1) mw++;
      n_cmp++; if (oState !== 4'(s[i])) begin n_err++; $display("FAIL sw_state[%0d] got %0d want %0d", i, oState, s[i]); end
      n_cmp++; if (obs() !== exp_ctrl(s[i], 1'b0)) begin n_err++; $display("FAIL sw_outs[%0d] got %h want %h", i, obs(), exp_ctrl(s[i], 1'b0)); end
      n_cmp++; if (oRegWrite !== 1'b0) begin n_err++; $display("FAIL sw_regwrite[%0d] got %b want 0", i, oRegWrite); end
    end
    n_cmp++; if (mw != 1) begin n_err++; $display("FAIL sw_memwrite_count got %0d want 1", mw); end
  endtask

  task automatic test_alu_ops();
    int s[3][5] = '{'{0, 1, 6, 7, 0}, '{0, 1, 8, 7, 0}, '{0, 1, 9, 7, 0}};
    logic [6:0] ops[3] = '{7'b0110011, 7'b0010011, 7'b1101111};
    for (int k = 0; k < 3; k++) begin
      iOpcode = ops[k];
      for (int i = 0; i < 5; i++) begin
        if (i > 0) tick();
        n_cmp++; if (oState !== 4'(s[k][i])) begin n_err++; $display("FAIL alu%0d_state[%0d] got %0d want %0d", k, i, oState, s[k][i]); end
        n_cmp++; if (obs() !== exp_ctrl(s[k][i], 1'b0)) begin n_err++; $display("FAIL alu%0d_outs[%0d] got %h want %h", k, i, obs(), exp_ctrl(s[k][i], 1'b0)); end
        n_cmp++; if ((oRegWrite & oMemWrite) !== 1'b0) begin n_err++; $display("FAIL alu%0d_strobes[%0d] got rw=%b mw=%b want not both", k, i, oRegWrite, oMemWrite); end
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3[5]  = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b010};
    logic       z[5]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       pcw[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       ill[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int s[4] = '{0, 1, 10, 0};
    iOpcode = 7'b1100011;
    for (int k = 0; k < 5; k++) begin
      iFunct3 = f3[k]; iZero = z[k];
      for (int i = 0; i < 4; i++) begin
        if (i > 0) tick();
        n_cmp++; if (oState !== 4'(s[i])) begin n_err++; $display("FAIL br%0d_state[%0d] got %0d want %0d", k, i, oState, s[i]); end
        n_cmp++; if (obs() !== exp_ctrl(s[i], pcw[k])) begin n_err++; $display("FAIL br%0d_outs[%0d] got %h want %h", k, i, obs(), exp_ctrl(s[i], pcw[k])); end
        n_cmp++; if (oIllegal !== ((s[i] == 10) ? ill[k] : 1'b0)) begin n_err++; $display("FAIL br%0d_illegal[%0d] got %b want %b", k, i, oIllegal, (s[i] == 10) ? ill[k] : 1'b0); end
      end
    end
    iFunct3 = 3'b000; iZero = 1'b0;
  endtask

  task automatic test_illegal();
    int s[3] = '{0, 1, 0};
    iOpcode = 7'b1111111;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      n_cmp++; if (oState !== 4'(s[i])) begin n_err++; $display("FAIL ill_state[%0d] got %0d want %0d", i, oState, s[i]); end
      n_cmp++; if (oIllegal !== (i == 1)) begin n_err++; $display("FAIL ill_pulse[%0d] got %b want %b", i, oIllegal, i == 1); end
      n_cmp++; if ({oRegWrite, oMemWrite} !== 2'b00) begin n_err++; $display("FAIL ill_strobes[%0d] got %b want 00", i, {oRegWrite, oMemWrite}); end
    end
  endtask

  task automatic test_reset_mid_instr();
    int rw = 0;
    iOpcode = 7'b0000011;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (oState !== 4'd3) begin n_err++; $display("FAIL rmid_memread got %0d want 3", oState); end
    #2 iRst_n = 1'b0;
    #1;
    n_cmp++; if (oState !== 4'd0) begin n_err++; $display("FAIL rmid_async got %0d want 0", oState); end
    n_cmp++; if (obs() !== exp_ctrl(0, 1'b0)) begin n_err++; $display("FAIL rmid_outs got %h want %h", obs(), exp_ctrl(0, 1'b0)); end
    @(posedge iClk); #1 iRst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) tick();
      if (oRegWrite === 1'b1) rw++;
      n_cmp++; if (oState !== 4'(i)) begin n_err++; $display("FAIL rmid_restart[%0d] got %0d want %0d", i, oState, i); end
    end
    n_cmp++; if (rw != 0) begin n_err++; $display("FAIL rmid_no_wb got %0d writes want 0", rw); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_alu_ops();
    test_branch();
    test_illegal();
    test_reset_mid_instr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got no end want finish");
    $fatal(1);
  end
endmodule

// File: doc/main_control.md
MAIN_CONTROL -- requirements
Module: main_control

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have these ports:
  iClk  in  1  sole clock, rising edge.
  iRst_n  in  1  asynchronous, active-low reset.
  iOpcode  in  7  instr[6:0] from the instruction register.
  iFunct3  in  3  instr[14:12], selects branch sense.
  iZero  in  1  ALU zero flag, same cycle.
  oALUOp  out  2  drives the ALU decoder select: 00 add, 01 sub, 10 R-type funct decode, 11 I-type funct3 decode.
  oALUSrcA  out  2  00 PC, 01 oldPC, 10 rs1.
  oALUSrcB  out  2  00 rs2, 01 imm, 10 constant 4.
  oResultSrc  out  2  00 ALUOut register, 01 memory data register, 10 ALU result.
  oAdrSrc  out  1  0 PC, 1 result bus.
  oIRWrite  out  1  load the instruction register.
  oPCWrite  out  1  load PC.
  oRegWrite  out  1  register file write.
  oMemWrite  out  1  data memory write.
  oState  out  4  current state encoding (debug).
  oIllegal  out  1  one-cycle pulse on an unsupported opcode or branch funct3.

Function
REQ-003 The block SHALL be a multicycle control FSM with a registered state and these encodings:
  FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BRANCH=10.
  Codes 11-15 SHALL go to FETCH on the next edge.
REQ-004 Transitions SHALL be:
  FETCH->DECODE.
  DECODE by iOpcode:
    0000011 or 0100011 -> MEMADR.
    0110011 -> EXECR.
    0010011 -> EXECI.
    1100011 -> BRANCH.
    1101111 -> JAL.
    any other value -> FETCH.
  MEMADR -> MEMREAD if iOpcode=0000011, else MEMWRITE.
  MEMREAD->MEMWB; EXECR->ALUWB; EXECI->ALUWB; JAL->ALUWB.
  MEMWB, MEMWRITE, ALUWB, BRANCH -> FETCH.
REQ-005 Every output not listed for a state SHALL be 0. Per-state outputs:
  FETCH: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10, ALUOp=00.
  DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  MEMREAD: AdrSrc=1, ResultSrc=00.
  MEMWB: ResultSrc=01, RegWrite=1.
  MEMWRITE: AdrSrc=1, MemWrite=1.
  EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=11.
  ALUWB: ResultSrc=00, RegWrite=1.
  JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
  BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite per REQ-006.
REQ-006 BRANCH oPCWrite SHALL be combinational from iZero and iFunct3:
  funct3=000 (beq): oPCWrite=iZero.
  funct3=001 (bne): oPCWrite=~iZero.
  any other funct3: oPCWrite=0.
REQ-007 oIllegal SHALL be combinational and high for exactly one cycle in either case:
  DECODE with an opcode outside REQ-004.
  BRANCH with iFunct3 not 000/001.
REQ-008 Cycles from FETCH to the next FETCH SHALL be: lw 5, sw 4, R 4, I 4, jal 4, branch 3, illegal 2.
REQ-009 All outputs other than oPCWrite (BRANCH) and oIllegal SHALL be pure functions of state (Moore).
REQ-010 oMemWrite and oRegWrite SHALL never be high in the same cycle.
REQ-011 iOpcode SHALL be sampled only in DECODE and MEMADR; changes in other states SHALL have no effect.

Reset
REQ-012 When iRst_n=0, state SHALL be forced to FETCH immediately, independent of iClk.
REQ-013 During reset, outputs SHALL equal the FETCH values of REQ-005, with oIllegal=0.
REQ-014 The first rising edge after iRst_n deasserts SHALL move to DECODE.
REQ-015 Reset asserted mid-instruction SHALL abandon that instruction; no further RegWrite or MemWrite pulse SHALL occur for it.

Verification
REQ-016 The bench SHALL cover these scenarios:
  lw (0000011): oState sequence 0,1,2,3,4,0; oRegWrite=1 only in state 4 with oResultSrc=01; oALUOp=00 throughout.
  sw (0100011): sequence 0,1,2,5,0; oMemWrite=1 exactly one cycle with oAdrSrc=1; oRegWrite never 1.
  add (0110011) then addi (0010011): EXECR shows oALUOp=10, oALUSrcB=00; EXECI shows oALUOp=11, oALUSrcB=01; both go to ALUWB.
  beq/bne (1100011): the four cases funct3=000/iZero=1, 000/0, 001/0, 001/1 give oPCWrite 1,0,1,0 in BRANCH; oALUOp=01; sequence 0,1,10,0.
  Illegal opcode 1111111: oIllegal=1 in DECODE, back to FETCH next edge, no write strobes; funct3=010 in BRANCH also pulses oIllegal with oPCWrite=0.
  iRst_n pulled low asynchronously in MEMREAD: oState=0 before the next iClk edge; after release, the sequence restarts at 0,1 with no MEMWB write.
